// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy -- SD card CMD line serializer / response deserializer.
//
// Sends one 48-bit command frame (start, transmission, index, argument,
// CRC7, end) MSB first on the CMD line. When a response is expected, it
// waits for the card's start bit and shifts in a 48-bit response, then
// checks that response's CRC7 and framing bits.
//
// Ports:
//   clock, reset           system clock; asynchronous active-high reset
//   cmd_start              one-cycle request, honoured only in IDLE
//   cmd_index, cmd_arg     command fields, latched on acceptance
//   resp_type              00 = no response, otherwise 48-bit response
//   cmd_pin_in             CMD line from the card
//   cmd_pin_out, cmd_oe    CMD line to the card and its drive enable
//   busy                   high whenever not IDLE
//   cmd_done               one-cycle completion pulse
//   resp_index, resp_arg   last received response fields
//   err_timeout/crc/frame  status of the last command, valid with cmd_done
module sd_cmd_phy (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    input  logic        cmd_pin_in,
    output logic        cmd_pin_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        cmd_done,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        err_timeout,
    output logic        err_crc,
    output logic        err_frame
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP,
        S_RECV,
        S_DONE
    } state_t;

    // Last WAIT_RESP cycle count before giving up. The window is sized so
    // that cmd_done lands exactly 64 cycles after the transmitted end bit.
    localparam logic [5:0] WAIT_LAST = 6'd62;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] tx_q, tx_d;
    logic [6:0]  crc_q, crc_d;
    logic [45:0] rx_q, rx_d;
    logic [1:0]  resp_type_q, resp_type_d;
    logic [5:0]  resp_index_q, resp_index_d;
    logic [31:0] resp_arg_q, resp_arg_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_crc_q, err_crc_d;
    logic        err_frame_q, err_frame_d;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tx_q          <= '0;
            crc_q         <= '0;
            rx_q          <= '0;
            resp_type_q   <= '0;
            resp_index_q  <= '0;
            resp_arg_q    <= '0;
            err_timeout_q <= 1'b0;
            err_crc_q     <= 1'b0;
            err_frame_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_q          <= tx_d;
            crc_q         <= crc_d;
            rx_q          <= rx_d;
            resp_type_q   <= resp_type_d;
            resp_index_q  <= resp_index_d;
            resp_arg_q    <= resp_arg_d;
            err_timeout_q <= err_timeout_d;
            err_crc_q     <= err_crc_d;
            err_frame_q   <= err_frame_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_d          = tx_q;
        crc_d         = crc_q;
        rx_d          = rx_q;
        resp_type_d   = resp_type_q;
        resp_index_d  = resp_index_q;
        resp_arg_d    = resp_arg_q;
        err_timeout_d = err_timeout_q;
        err_crc_d     = err_crc_q;
        err_frame_d   = err_frame_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    tx_d          = {1'b0, 1'b1, cmd_index, cmd_arg};
                    resp_type_d   = resp_type;
                    cnt_d         = '0;
                    crc_d         = '0;
                    err_timeout_d = 1'b0;
                    err_crc_d     = 1'b0;
                    err_frame_d   = 1'b0;
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q < 6'd40) begin
                    // Header/argument bits leave from tx_q[39] and feed the CRC.
                    tx_d  = {tx_q[38:0], 1'b0};
                    crc_d = crc7_step(crc_q, tx_q[39]);
                end else if (cnt_q < 6'd47) begin
                    // CRC bits leave from crc_q[6].
                    crc_d = {crc_q[5:0], 1'b0};
                end else begin
                    cnt_d   = '0;
                    crc_d   = '0;
                    state_d = (resp_type_q == 2'b00) ? S_DONE : S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (!cmd_pin_in) begin
                    // The start bit is 0, so it leaves the zero CRC untouched.
                    cnt_d   = '0;
                    state_d = S_RECV;
                end else if (cnt_q == WAIT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_RECV: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q < 6'd46) begin
                    rx_d = {rx_q[44:0], cmd_pin_in};
                    // Bits 0..38 (transmission, index, payload) are covered by the CRC.
                    if (cnt_q < 6'd39)
                        crc_d = crc7_step(crc_q, cmd_pin_in);
                end else begin
                    // cmd_pin_in is the end bit; rx_q = {trans, index, arg, crc}.
                    resp_index_d = rx_q[44:39];
                    resp_arg_d   = rx_q[38:7];
                    err_crc_d    = (rx_q[6:0] != crc_q);
                    err_frame_d  = rx_q[45] | ~cmd_pin_in;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output bit selection is combinational from state so that cmd_oe
    // follows the asynchronous reset immediately.
    always_comb begin
        cmd_pin_out = 1'b1;
        if (state_q == S_SEND) begin
            if (cnt_q < 6'd40)
                cmd_pin_out = tx_q[39];
            else if (cnt_q < 6'd47)
                cmd_pin_out = crc_q[6];
        end
    end

    assign cmd_oe      = (state_q == S_SEND);
    assign busy        = (state_q != S_IDLE);
    assign cmd_done    = (state_q == S_DONE);
    assign resp_index  = resp_index_q;
    assign resp_arg    = resp_arg_q;
    assign err_timeout = err_timeout_q;
    assign err_crc     = err_crc_q;
    assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed testbench for sd_cmd_phy: known SD command frames, a card
// response model driven bit by bit, timeout, CRC/frame errors, mid-frame
// reset and ignored start requests.
module tb_sd_cmd_phy;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic [1:0]  resp_type = '0;
    logic        cmd_pin_in = 1'b1;
    logic        cmd_pin_out, cmd_oe, busy, cmd_done;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        err_timeout, err_crc, err_frame;

    int errors = 0;
    int checks = 0;

    sd_cmd_phy dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
        .cmd_pin_in(cmd_pin_in), .cmd_pin_out(cmd_pin_out), .cmd_oe(cmd_oe),
        .busy(busy), .cmd_done(cmd_done), .resp_index(resp_index),
        .resp_arg(resp_arg), .err_timeout(err_timeout), .err_crc(err_crc),
        .err_frame(err_frame)
    );

    always #5 clock = ~clock;

    // Called at a negedge in an IDLE cycle. Requests a command, then corrupts
    // the inputs and captures the 48 transmitted bits. Returns at the negedge
    // of the cycle following the end bit (cycle 49). pulse_at >= 0 raises
    // cmd_start during that bit time to show it is ignored.
    task automatic start_and_capture(input logic [5:0] idx, input logic [31:0] arg,
                                     input logic [1:0] rt, input int pulse_at,
                                     output logic [47:0] frame);
        logic oe_ok;
        cmd_index = idx; cmd_arg = arg; resp_type = rt; cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        cmd_index = ~idx; cmd_arg = ~arg; resp_type = (rt == 2'b00) ? 2'b01 : 2'b00;
        oe_ok = 1'b1;
        frame = '0;
        for (int i = 0; i < 48; i++) begin
            frame = {frame[46:0], cmd_pin_out};
            if (cmd_oe !== 1'b1) oe_ok = 1'b0;
            cmd_start = (i == pulse_at);
            @(negedge clock);
        end
        cmd_start = 1'b0;
        checks++;
        if (!oe_ok || cmd_oe !== 1'b0) begin
            errors++;
            $display("FAIL oe_window cmd=%0d: oe high all 48 bits=%b, oe after end=%b, required 1 and 0",
                     idx, oe_ok, cmd_oe);
        end
    endtask

    // Card model: idle-high cycles then a 48-bit response, MSB first.
    // Returns at the negedge of the cycle after the response end bit.
    task automatic drive_response(input logic [47:0] resp, input int idle);
        for (int i = 0; i < idle; i++) begin
            cmd_pin_in = 1'b1;
            @(negedge clock);
        end
        for (int i = 47; i >= 0; i--) begin
            cmd_pin_in = resp[i];
            @(negedge clock);
        end
        cmd_pin_in = 1'b1;
    endtask

    task automatic check_status(input string name, input logic [2:0] exp_err,
                                input logic [5:0] exp_idx, input logic [31:0] exp_arg);
        checks++;
        if (cmd_done !== 1'b1 || {err_timeout, err_crc, err_frame} !== exp_err ||
            resp_index !== exp_idx || resp_arg !== exp_arg) begin
            errors++;
            $display("FAIL %s: done=%b errs(t,c,f)=%b idx=%h arg=%h, required done=1 errs=%b idx=%h arg=%h",
                     name, cmd_done, {err_timeout, err_crc, err_frame}, resp_index, resp_arg,
                     exp_err, exp_idx, exp_arg);
        end
    endtask

    task automatic check_frame(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: frame=%h required %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (cmd_pin_out !== 1'b1 || cmd_oe !== 1'b0 || busy !== 1'b0 || cmd_done !== 1'b0 ||
            resp_index !== 6'd0 || resp_arg !== 32'd0 ||
            {err_timeout, err_crc, err_frame} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: pin=%b oe=%b busy=%b done=%b idx=%h arg=%h errs=%b",
                     cmd_pin_out, cmd_oe, busy, cmd_done, resp_index, resp_arg,
                     {err_timeout, err_crc, err_frame});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_cmd0();
        logic [47:0] f;
        start_and_capture(6'd0, 32'h0, 2'b00, -1, f);
        check_frame("cmd0_frame", f, 48'h400000000095);
        check_status("cmd0_done", 3'b000, 6'd0, 32'd0);
        @(negedge clock);
        checks++;
        if (cmd_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cmd0_idle: done=%b busy=%b required 0 0", cmd_done, busy);
        end
    endtask

    task automatic test_cmd8_resp();
        logic [47:0] f;
        start_and_capture(6'd8, 32'h000001AA, 2'b01, -1, f);
        check_frame("cmd8_frame", f, 48'h48000001AA87);
        checks++;
        if (busy !== 1'b1 || cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL cmd8_wait: busy=%b done=%b required 1 0", busy, cmd_done);
        end
        drive_response(48'h08000001AA13, 10);
        check_status("cmd8_resp", 3'b000, 6'h08, 32'h000001AA);
        @(negedge clock);
    endtask

    task automatic test_timeout();
        logic [47:0] f;
        int n;
        start_and_capture(6'd17, 32'h0, 2'b01, -1, f);
        check_frame("cmd17_frame", f, 48'h510000000055);
        // Now in the cycle after the end bit; cmd_done is due 63 cycles later.
        n = 0;
        while (cmd_done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 63) begin
            errors++;
            $display("FAIL timeout_latency: cmd_done after %0d cycles required 63", n);
        end
        // Previous response fields hold through a command without RECV.
        check_status("timeout_status", 3'b100, 6'h08, 32'h000001AA);
        @(negedge clock);
    endtask

    task automatic test_crc_error();
        logic [47:0] f;
        start_and_capture(6'd8, 32'h000001AA, 2'b01, -1, f);
        drive_response(48'h08000001AA25, 10);
        check_status("crc_error", 3'b010, 6'h08, 32'h000001AA);
        @(negedge clock);
    endtask

    task automatic test_frame_error();
        logic [47:0] f;
        start_and_capture(6'd8, 32'h000001AA, 2'b01, -1, f);
        drive_response(48'h08000001AA13 | 48'h400000000000, 3);
        checks++;
        if (cmd_done !== 1'b1 || err_frame !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL frame_error: done=%b frame=%b timeout=%b required 1 1 0",
                     cmd_done, err_frame, err_timeout);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_frame();
        logic [47:0] f;
        logic saw_done;
        cmd_index = 6'd8; cmd_arg = 32'h000001AA; resp_type = 2'b01; cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        repeat (20) @(negedge clock);
        // TX bit 20 is on the line now.
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_oe !== 1'b0 || cmd_pin_out !== 1'b1 || busy !== 1'b0 ||
            resp_index !== 6'd0 || {err_timeout, err_crc, err_frame} !== 3'b000) begin
            errors++;
            $display("FAIL reset_abort: oe=%b pin=%b busy=%b idx=%h errs=%b required 0 1 0 00 000",
                     cmd_oe, cmd_pin_out, busy, resp_index, {err_timeout, err_crc, err_frame});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (cmd_done !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (cmd_done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done: cmd_done/busy seen after abort, required none");
        end
        start_and_capture(6'd0, 32'h0, 2'b00, -1, f);
        check_frame("post_reset_cmd0", f, 48'h400000000095);
        check_status("post_reset_done", 3'b000, 6'd0, 32'd0);
        @(negedge clock);
    endtask

    task automatic test_ignore_start();
        logic [47:0] f;
        logic extra;
        start_and_capture(6'd0, 32'h0, 2'b00, 10, f);
        check_frame("ignore_frame", f, 48'h400000000095);
        check_status("ignore_done", 3'b000, 6'd0, 32'd0);
        cmd_start = 1'b1;          // request during the DONE cycle
        @(negedge clock);
        cmd_start = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (busy !== 1'b0 || cmd_oe !== 1'b0) extra = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL ignore_start: extra activity after DONE, required idle");
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] f;
        start_and_capture(6'd8, 32'h000001AA, 2'b01, -1, f);
        drive_response(48'h08000001AA13, 0);
        check_status("b2b_first", 3'b000, 6'h08, 32'h000001AA);
        @(negedge clock);          // first IDLE cycle after DONE
        start_and_capture(6'd0, 32'h0, 2'b00, -1, f);
        check_frame("b2b_frame", f, 48'h400000000095);
        check_status("b2b_second", 3'b000, 6'h08, 32'h000001AA);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8_resp();
        test_timeout();
        test_crc_error();
        test_frame_error();
        test_reset_mid_frame();
        test_ignore_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_phy.md
SD_CMD_PHY -- requirements
Module: sd_cmd_phy

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port cmd_start  input  1  one-cycle request to issue a command, sampled only in IDLE.
REQ-004 SHALL have port cmd_index  input  6  command index, taken from command register bits 13:8.
REQ-005 SHALL have port cmd_arg  input  32  command argument, taken from argument register.
REQ-006 SHALL have port resp_type  input  2  00 no response, 01/10/11 48-bit response expected.
REQ-007 SHALL have port cmd_pin_in  input  1  serial CMD line from card.
REQ-008 SHALL have port cmd_pin_out  output  1  serial CMD line to card, idle high.
REQ-009 SHALL have port cmd_oe  output  1  CMD line drive enable.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port cmd_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_index  output  6  received response index.
REQ-013 SHALL have port resp_arg  output  32  received response payload.
REQ-014 SHALL have port err_timeout, err_crc, err_frame  output  1 each  status of last command, valid with cmd_done.

Function
REQ-015 SHALL implement states IDLE, SEND, WAIT_RESP, RECV, DONE.
REQ-016 In IDLE with cmd_start=1, SHALL latch cmd_index, cmd_arg, resp_type and enter SEND next cycle; later input changes do not affect the frame.
REQ-017 SHALL send a 48-bit frame MSB first, one bit per clock: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
REQ-018 SHALL compute CRC7 with polynomial x^7+x^3+1 and initial value 0 over the first 40 frame bits.
REQ-019 Frame bit n (n=0..47) SHALL appear on cmd_pin_out in cycle n+1 after the cycle cmd_start is sampled; cmd_oe SHALL be high in exactly those 48 cycles.
REQ-020 Outside SEND, cmd_oe SHALL be 0 and cmd_pin_out SHALL be 1.
REQ-021 After the end bit, resp_type=00 SHALL go to DONE; any other value SHALL go to WAIT_RESP.
REQ-022 WAIT_RESP SHALL sample cmd_pin_in each cycle; the first 0 is the response start bit and SHALL enter RECV.
REQ-023 If no start bit arrives within 64 cycles of entering WAIT_RESP, SHALL set err_timeout and go to DONE.
REQ-024 RECV SHALL shift in the remaining 47 bits: transmission, index, payload, CRC7, end.
REQ-025 SHALL recompute CRC7 over the received first 40 bits; a mismatch with received CRC SHALL set err_crc.
REQ-026 Transmission bit not 0 or end bit not 1 SHALL set err_frame.
REQ-027 resp_index and resp_arg SHALL update only at the end of RECV and hold until the next RECV completes.
REQ-028 DONE SHALL last one cycle with cmd_done=1, then return to IDLE.
REQ-029 Error flags SHALL clear when a new command is accepted and hold from cmd_done until then.
REQ-030 cmd_start outside IDLE, including in the DONE cycle, SHALL be ignored with no queuing.
REQ-031 Back-to-back: cmd_start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-032 While reset=1, SHALL force: state IDLE, cmd_pin_out=1, cmd_oe=0, busy=0, cmd_done=0, resp_index=0, resp_arg=0, all error flags 0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no cmd_done pulse; cmd_oe SHALL drop asynchronously.

Verification
REQ-034 CMD0, arg 0x00000000, resp_type 00 -> cmd_pin_out over 48 cycles = 0x400000000095, then cmd_done at cycle 49, no errors.
REQ-035 CMD8, arg 0x000001AA, resp_type 01, card returns 0x08000001AA13 after 10 idle cycles -> TX frame 0x48000001AA87, resp_index=0x08, resp_arg=0x000001AA, no errors.
REQ-036 CMD17, arg 0x00000000, resp_type 01, cmd_pin_in held high -> TX 0x510000000055, err_timeout=1 with cmd_done 64 cycles after the end bit.
REQ-037 Same as REQ-035 with the response CRC altered to 0x12 -> err_crc=1, err_frame=0, resp_arg still 0x000001AA.
REQ-038 Reset asserted at TX bit 20 of CMD8 -> cmd_oe=0, cmd_pin_out=1 at once, no cmd_done; a following CMD0 request -> frame identical to REQ-034.
REQ-039 cmd_start pulsed during SEND and in the DONE cycle -> ignored, exactly one frame transmitted.
